// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush/halt sequencer for the 5-stage core (optional counters: STALL_CNT_EN)
module hazard_stall_ctrl #(
  parameter int MAX_STALL = 3,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             conflict,
  input  logic             redirect,
  input  logic             halt_req,
  input  logic             go,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             halted,
  output logic             stall_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;
  localparam int LW = $clog2(MAX_STALL + 2);
  localparam logic [LW-1:0] LEN_SAT = LW'(MAX_STALL + 1);
  state_t state, next;
  logic [LW-1:0] len, len_next;
  logic err;
  // state, stall length and sticky runaway flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      len   <= '0;
      err   <= 1'b0;
    end else begin
      state <= next;
      len   <= len_next;
      err   <= err | (len_next > LW'(MAX_STALL));
    end
  end
  // next state: HALT waits for go; otherwise halt_req > redirect > conflict
  always_comb begin
    next     = RUN;
    len_next = '0;
    if (state == HALT) next = go ? RUN : HALT;
    else if (halt_req) next = HALT;
    else if (redirect) next = RUN;
    else if (conflict) begin
      next     = STALL;
      len_next = (len == LEN_SAT) ? len : len + 1'b1;
    end
  end
  // outputs decode combinationally; reset forces the free-running values
  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    if_id_clr = 1'b0;
    id_ex_clr = 1'b0;
    if (!rst_n) begin
      pc_en = 1'b1;
    end else if (state == HALT || halt_req || (!redirect && conflict)) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_clr = 1'b1;
    end else if (redirect) begin
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end
  end
  assign halted    = rst_n && state == HALT;
  assign stall_err = err;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  // performance counters: stalled cycles outside HALT and honoured redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (state != HALT && !pc_en) stall_q <= stall_q + 1'b1;
      if (if_id_clr) flush_q <= flush_q + 1'b1;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule
